// File: rtl/gen_pad_pkg.sv
// Shared types and constants for the Mega Drive pad reader.
//   state_t  : FSM encoding; PHASE states are 0..7 so bit 0 equals the TH level
//   btn_t    : held button states, active-low (1 = released)
//   D_*      : data-pin bit positions within {D5..D0} for each sampled phase
package gen_pad_pkg;

  localparam int unsigned SETTLE_DEF = 16;
  localparam int unsigned GAP_DEF    = 12000;
  localparam int unsigned SETTLE_W   = 5;
  localparam int unsigned GAP_W      = 14;
  localparam int unsigned PIN_W      = 6;

  // TH high, first pass
  localparam int unsigned D_UP    = 0;
  localparam int unsigned D_DOWN  = 1;
  localparam int unsigned D_LEFT  = 2;
  localparam int unsigned D_RIGHT = 3;
  localparam int unsigned D_B     = 4;
  localparam int unsigned D_C     = 5;
  // TH low
  localparam int unsigned D_A     = 4;
  localparam int unsigned D_START = 5;
  // TH high, extra-button pass of a 6-button pad
  localparam int unsigned D_Z     = 0;
  localparam int unsigned D_Y     = 1;
  localparam int unsigned D_X     = 2;
  localparam int unsigned D_MODE  = 3;

  typedef enum logic [3:0] {
    ST_PH0  = 4'd0,
    ST_PH1  = 4'd1,
    ST_PH2  = 4'd2,
    ST_PH3  = 4'd3,
    ST_PH4  = 4'd4,
    ST_PH5  = 4'd5,
    ST_PH6  = 4'd6,
    ST_PH7  = 4'd7,
    ST_IDLE = 4'd8,
    ST_GAP  = 4'd9
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic a;
    logic b;
    logic c;
    logic start;
    logic mode;
    logic x;
    logic y;
    logic z;
  } btn_t;

  localparam btn_t BTN_RELEASED = '1;

  // TH level for a state: phase parity during a sequence, otherwise high
  function automatic logic th_level(input state_t s);
    logic [3:0] v;
    v = 4'(s);
    return (v <= 4'd7) ? v[0] : 1'b1;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data pins.
//   clk, rst : system clock, synchronous active-high reset
//   d        : raw pins
//   q        : synchronized pins (reset to all-released)
module pad_sync #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/md_pad_reader.sv
// Host-side Mega Drive 3/6-button pad reader. Steps TH through the 8-phase
// select sequence, samples the data pins, detects pad presence and type, and
// commits active-low button states atomically at sequence end.
//   CLK, RESET, CE   : clock, sync active-high reset, clock enable for FSM/timers
//   POLL, FORCE3     : start request (IDLE only), 3-button-only mode
//   PAD_DI           : raw pad pins {D5..D0}
//   PAD_TH, PAD_TR   : select line, TR held high
//   P_*              : held buttons, 1 = released
//   PRESENT, SIX_BTN : pad detection results of the last completed sequence
//   BUSY, VALID      : sequence/gap in progress, one-CLK output-update pulse
module md_pad_reader
  import gen_pad_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEF,
  parameter int unsigned GAP    = GAP_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             POLL,
  input  logic             FORCE3,
  input  logic [PIN_W-1:0] PAD_DI,
  output logic             PAD_TH,
  output logic             PAD_TR,
  output logic             P_UP,
  output logic             P_DOWN,
  output logic             P_LEFT,
  output logic             P_RIGHT,
  output logic             P_A,
  output logic             P_B,
  output logic             P_C,
  output logic             P_START,
  output logic             P_MODE,
  output logic             P_X,
  output logic             P_Y,
  output logic             P_Z,
  output logic             PRESENT,
  output logic             SIX_BTN,
  output logic             BUSY,
  output logic             VALID
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP - 1);

  logic [PIN_W-1:0]    di;
  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                th_q, th_d;
  logic                force3_q, force3_d;
  logic                sh_six_q, sh_six_d;
  btn_t                sh_q, sh_d;
  btn_t                btn_q, btn_d;
  logic                present_q, present_d;
  logic                six_btn_q, six_btn_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                settle_done;
  logic                gap_done;

  pad_sync #(.W(PIN_W)) u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (PAD_DI),
    .q   (di)
  );

  // Saturating compares so a short parameter can never cause a wrap
  assign settle_done = (settle_q >= SETTLE_LAST);
  assign gap_done    = (gap_q >= GAP_LAST);

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      gap_q     <= '0;
      th_q      <= 1'b1;
      force3_q  <= 1'b0;
      sh_six_q  <= 1'b0;
      sh_q      <= BTN_RELEASED;
      btn_q     <= BTN_RELEASED;
      present_q <= 1'b0;
      six_btn_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      gap_q     <= gap_d;
      th_q      <= th_d;
      force3_q  <= force3_d;
      sh_six_q  <= sh_six_d;
      sh_q      <= sh_d;
      btn_q     <= btn_d;
      present_q <= present_d;
      six_btn_q <= six_btn_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state, sampling and commit logic
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    gap_d     = gap_q;
    force3_d  = force3_q;
    sh_six_d  = sh_six_q;
    sh_d      = sh_q;
    btn_d     = btn_q;
    present_d = present_q;
    six_btn_d = six_btn_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (POLL) begin
          state_d  = ST_PH0;
          settle_d = '0;
          force3_d = FORCE3;
          sh_six_d = 1'b0;
          sh_d     = BTN_RELEASED;
        end
      end

      ST_GAP: begin
        if (CE) begin
          if (gap_done) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      ST_PH0, ST_PH1, ST_PH2, ST_PH3, ST_PH4, ST_PH5, ST_PH6, ST_PH7: begin
        if (CE) begin
          if (!settle_done) begin
            settle_d = settle_q + SETTLE_W'(1);
          end else begin
            settle_d = '0;
            state_d  = state_t'(4'(state_q) + 4'd1);
            case (state_q)
              ST_PH0: begin
                sh_d.start = di[D_START];
                sh_d.a     = di[D_A];
                // A connected pad always drives D3:D2 low while TH is low
                if (di[3:2] != 2'b00) begin
                  btn_d     = BTN_RELEASED;
                  present_d = 1'b0;
                  six_btn_d = 1'b0;
                  valid_d   = 1'b1;
                  state_d   = ST_GAP;
                  gap_d     = '0;
                end
              end
              ST_PH1: begin
                sh_d.c     = di[D_C];
                sh_d.b     = di[D_B];
                sh_d.right = di[D_RIGHT];
                sh_d.left  = di[D_LEFT];
                sh_d.down  = di[D_DOWN];
                sh_d.up    = di[D_UP];
                if (force3_q) begin
                  btn_d      = sh_d;
                  btn_d.mode = 1'b1;
                  btn_d.x    = 1'b1;
                  btn_d.y    = 1'b1;
                  btn_d.z    = 1'b1;
                  present_d  = 1'b1;
                  six_btn_d  = 1'b0;
                  valid_d    = 1'b1;
                  state_d    = ST_GAP;
                  gap_d      = '0;
                end
              end
              ST_PH4: begin
                // Third TH-low phase: a 6-button pad pulls D3:D0 all low
                sh_six_d = (di[3:0] == 4'b0000);
              end
              ST_PH5: begin
                if (sh_six_q) begin
                  sh_d.mode = di[D_MODE];
                  sh_d.x    = di[D_X];
                  sh_d.y    = di[D_Y];
                  sh_d.z    = di[D_Z];
                end
              end
              ST_PH7: begin
                btn_d = sh_q;
                if (!sh_six_q) begin
                  btn_d.mode = 1'b1;
                  btn_d.x    = 1'b1;
                  btn_d.y    = 1'b1;
                  btn_d.z    = 1'b1;
                end
                present_d = 1'b1;
                six_btn_d = sh_six_q;
                valid_d   = 1'b1;
                state_d   = ST_GAP;
                gap_d     = '0;
              end
              default: begin
              end
            endcase
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // TH follows the state being entered so edges coincide with phase entry
    th_d   = th_level(state_d);
    busy_d = (state_d != ST_IDLE);
  end

  assign PAD_TH  = th_q;
  assign PAD_TR  = 1'b1;
  assign P_UP    = btn_q.up;
  assign P_DOWN  = btn_q.down;
  assign P_LEFT  = btn_q.left;
  assign P_RIGHT = btn_q.right;
  assign P_A     = btn_q.a;
  assign P_B     = btn_q.b;
  assign P_C     = btn_q.c;
  assign P_START = btn_q.start;
  assign P_MODE  = btn_q.mode;
  assign P_X     = btn_q.x;
  assign P_Y     = btn_q.y;
  assign P_Z     = btn_q.z;
  assign PRESENT = present_q;
  assign SIX_BTN = six_btn_q;
  assign BUSY    = busy_q;
  assign VALID   = valid_q;

endmodule

// File: tb/tb_md_pad_reader.sv
// Directed bench for md_pad_reader with a behavioural 3/6-button pad responder.
module tb_md_pad_reader;

  localparam int B_UP = 11, B_DOWN = 10, B_LEFT = 9, B_RIGHT = 8, B_A = 7, B_B = 6;
  localparam int B_C = 5, B_START = 4, B_MODE = 3, B_X = 2, B_Y = 1, B_Z = 0;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic CE = 1'b0;
  logic POLL = 1'b0;
  logic FORCE3 = 1'b0;
  logic [5:0] PAD_DI;
  logic PAD_TH, PAD_TR;
  logic P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START, P_MODE, P_X, P_Y, P_Z;
  logic PRESENT, SIX_BTN, BUSY, VALID;
  logic [11:0] btns;

  // pad model controls: press bit = 1 means held
  logic [11:0] press = '0;
  logic [11:0] rel;
  logic no_pad = 1'b0;
  logic j3but = 1'b0;
  logic pad_clr = 1'b0;
  int fall_cnt = 0;

  int checks = 0;
  int fails = 0;
  int ce_cnt = 0;
  int th_edges = 0;
  int valid_cnt = 0;
  logic th_prev = 1'b1;
  int de, dv, be, bv;

  md_pad_reader #(.SETTLE(4), .GAP(40)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .POLL(POLL), .FORCE3(FORCE3), .PAD_DI(PAD_DI),
    .PAD_TH(PAD_TH), .PAD_TR(PAD_TR),
    .P_UP(P_UP), .P_DOWN(P_DOWN), .P_LEFT(P_LEFT), .P_RIGHT(P_RIGHT),
    .P_A(P_A), .P_B(P_B), .P_C(P_C), .P_START(P_START),
    .P_MODE(P_MODE), .P_X(P_X), .P_Y(P_Y), .P_Z(P_Z),
    .PRESENT(PRESENT), .SIX_BTN(SIX_BTN), .BUSY(BUSY), .VALID(VALID)
  );

  assign btns = {P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START, P_MODE, P_X, P_Y, P_Z};
  assign rel  = ~press;

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    ce_cnt = (ce_cnt + 1) % 4;
    CE = (ce_cnt == 0);
  end

  always @(posedge CLK) begin
    #1;
    if (PAD_TH !== th_prev) th_edges++;
    th_prev = PAD_TH;
    if (VALID === 1'b1) valid_cnt++;
  end

  // pad-side TH falling-edge counter (third low phase selects the 6-button ID)
  always @(negedge PAD_TH or posedge pad_clr) begin
    if (pad_clr) fall_cnt = 0;
    else fall_cnt = fall_cnt + 1;
  end

  always_comb begin
    if (no_pad) begin
      PAD_DI = 6'h3F;
    end else if (PAD_TH === 1'b1) begin
      if (!j3but && fall_cnt == 3)
        PAD_DI = {rel[B_C], rel[B_B], rel[B_MODE], rel[B_X], rel[B_Y], rel[B_Z]};
      else
        PAD_DI = {rel[B_C], rel[B_B], rel[B_RIGHT], rel[B_LEFT], rel[B_DOWN], rel[B_UP]};
    end else begin
      if (!j3but && fall_cnt == 3)
        PAD_DI = {rel[B_START], rel[B_A], 4'b0000};
      else if (!j3but && fall_cnt == 4)
        PAD_DI = {rel[B_START], rel[B_A], 4'b1111};
      else
        PAD_DI = {rel[B_START], rel[B_A], 2'b00, rel[B_DOWN], rel[B_UP]};
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_poll();
    @(negedge CLK);
    POLL = 1'b1;
    @(negedge CLK);
    POLL = 1'b0;
  endtask

  task automatic clr_pad();
    pad_clr = 1'b1;
    #1;
    pad_clr = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && BUSY !== 1'b0; i++) @(negedge CLK);
    if (BUSY !== 1'b0) check_eq("busy_timeout", 16'(BUSY), 16'd0);
  endtask

  task automatic wait_edges(input int base, input int n);
    for (int i = 0; i < 1000 && (th_edges - base) < n; i++) @(negedge CLK);
    if ((th_edges - base) < n) check_eq("edge_timeout", 16'(th_edges - base), 16'(n));
  endtask

  task automatic wait_valid(input int base, input int n);
    for (int i = 0; i < 1000 && (valid_cnt - base) < n; i++) @(negedge CLK);
    if ((valid_cnt - base) < n) check_eq("valid_timeout", 16'(valid_cnt - base), 16'(n));
  endtask

  task automatic run_poll(output int d_edges, output int d_valid);
    int e0, v0;
    clr_pad();
    e0 = th_edges;
    v0 = valid_cnt;
    do_poll();
    wait_idle();
    d_edges = th_edges - e0;
    d_valid = valid_cnt - v0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_eq("rst_th", 16'(PAD_TH), 16'd1);
    check_eq("rst_tr", 16'(PAD_TR), 16'd1);
    check_eq("rst_btn", 16'(btns), 16'hFFF);
    check_eq("rst_present", 16'(PRESENT), 16'd0);
    check_eq("rst_six", 16'(SIX_BTN), 16'd0);
    check_eq("rst_busy", 16'(BUSY), 16'd0);
    check_eq("rst_valid", 16'(VALID), 16'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // 6-button pad, A+X+Up
    press = '0; press[B_A] = 1'b1; press[B_X] = 1'b1; press[B_UP] = 1'b1;
    run_poll(de, dv);
    check_eq("six_edges", 16'(de), 16'd8);
    check_eq("six_valid", 16'(dv), 16'd1);
    check_eq("six_btn", 16'(btns), 16'h77B);
    check_eq("six_flag", 16'(SIX_BTN), 16'd1);
    check_eq("six_present", 16'(PRESENT), 16'd1);
    check_eq("six_th", 16'(PAD_TH), 16'd1);

    // 3-button pad, C+Down (X held but unreadable)
    j3but = 1'b1;
    press = '0; press[B_C] = 1'b1; press[B_DOWN] = 1'b1; press[B_X] = 1'b1;
    run_poll(de, dv);
    check_eq("j3_edges", 16'(de), 16'd8);
    check_eq("j3_valid", 16'(dv), 16'd1);
    check_eq("j3_btn", 16'(btns), 16'hBDF);
    check_eq("j3_six", 16'(SIX_BTN), 16'd0);
    check_eq("j3_present", 16'(PRESENT), 16'd1);
    j3but = 1'b0;

    // no pad connected
    no_pad = 1'b1;
    run_poll(de, dv);
    check_eq("np_edges", 16'(de), 16'd2);
    check_eq("np_valid", 16'(dv), 16'd1);
    check_eq("np_btn", 16'(btns), 16'hFFF);
    check_eq("np_present", 16'(PRESENT), 16'd0);
    check_eq("np_th", 16'(PAD_TH), 16'd1);
    no_pad = 1'b0;

    // FORCE3 on a 6-button pad, Start+B+Z held
    press = '0; press[B_START] = 1'b1; press[B_B] = 1'b1; press[B_Z] = 1'b1;
    FORCE3 = 1'b1;
    run_poll(de, dv);
    FORCE3 = 1'b0;
    check_eq("f3_edges", 16'(de), 16'd2);
    check_eq("f3_valid", 16'(dv), 16'd1);
    check_eq("f3_btn", 16'(btns), 16'hFAF);
    check_eq("f3_six", 16'(SIX_BTN), 16'd0);
    check_eq("f3_present", 16'(PRESENT), 16'd1);

    // POLL during PHASE3 and during GAP must be dropped
    press = '0; press[B_Y] = 1'b1; press[B_MODE] = 1'b1; press[B_RIGHT] = 1'b1;
    clr_pad();
    be = th_edges;
    bv = valid_cnt;
    do_poll();
    wait_edges(be, 4);
    do_poll();
    wait_valid(bv, 1);
    repeat (3) @(negedge CLK);
    check_eq("gap_busy", 16'(BUSY), 16'd1);
    do_poll();
    wait_idle();
    check_eq("drop_edges", 16'(th_edges - be), 16'd8);
    check_eq("drop_valid", 16'(valid_cnt - bv), 16'd1);
    check_eq("drop_btn", 16'(btns), 16'hEF5);
    repeat (10) @(negedge CLK);
    check_eq("no_queue", 16'(BUSY), 16'd0);
    run_poll(de, dv);
    check_eq("after_valid", 16'(dv), 16'd1);
    check_eq("after_btn", 16'(btns), 16'hEF5);

    // RESET during PHASE5, with a coincident POLL
    clr_pad();
    be = th_edges;
    bv = valid_cnt;
    do_poll();
    wait_edges(be, 6);
    @(negedge CLK);
    RESET = 1'b1;
    POLL = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    POLL = 1'b0;
    check_eq("mrst_th", 16'(PAD_TH), 16'd1);
    check_eq("mrst_btn", 16'(btns), 16'hFFF);
    check_eq("mrst_present", 16'(PRESENT), 16'd0);
    check_eq("mrst_six", 16'(SIX_BTN), 16'd0);
    check_eq("mrst_busy", 16'(BUSY), 16'd0);
    repeat (20) @(negedge CLK);
    check_eq("mrst_nopoll", 16'(BUSY), 16'd0);
    check_eq("mrst_novalid", 16'(valid_cnt - bv), 16'd0);

    // back-to-back reads
    press = '0; press[B_A] = 1'b1;
    run_poll(de, dv);
    check_eq("b2b1_valid", 16'(dv), 16'd1);
    check_eq("b2b1_btn", 16'(btns), 16'hF7F);
    press = '0; press[B_START] = 1'b1; press[B_Z] = 1'b1;
    run_poll(de, dv);
    check_eq("b2b2_valid", 16'(dv), 16'd1);
    check_eq("b2b2_btn", 16'(btns), 16'hFEE);
    check_eq("b2b2_six", 16'(SIX_BTN), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
